button_event_capture: RTL
=========================

// Module: button_event_capture
// PURPOSE
// - Read side of the debounced-button path: converts the debounced, active-high button levels
//   into sticky per-button press events, with auto-repeat while a button is held.
// - Sits between the button debouncers and the CPU inputs PIO. Software sees events and an irq,
//   then acknowledges them with a write-1-to-clear pulse.
// PARAMETERS
// - N_BUTTONS             4   number of button channels.
// - REPEAT_DELAY_CYCLES   25_000_000   cycles from the press event to the first repeat
//                                      (0.5 s at 50 MHz). Value 0 disables auto-repeat.
// - REPEAT_PERIOD_CYCLES  5_000_000    cycles between later repeats (0.1 s). Must be >= 1.
// - CNT_W                 $clog2(max(delay,period)+1)   counter width; derived, not overridden.
// PORTS
// - clk            in   1           system clock; the only clock.
// - reset          in   1           asynchronous, active-high reset.
// - buttons_in     in   N_BUTTONS   debounced levels, 1 = pressed; already synchronous to clk.
// - event_clear    in   N_BUTTONS   write-1-to-clear pulse per bit, from the CPU.
// - events_out     out  N_BUTTONS   sticky event flags.
// - overrun_out    out  N_BUTTONS   sticky: an event arrived while that bit was still pending.
// - held_out       out  N_BUTTONS   1 while that channel's FSM is not IDLE.
// - irq            out  1           |events_out.
// BEHAVIOUR
// - Reset (async assert, sync deassert is the top level's job):
//   - events_out, overrun_out, held_out and irq are 0.
//   - All FSMs go to IDLE; all counters go to 0.
// - Per-channel FSM (IDLE, DELAY, REPEAT) with counter cnt. A strobe is a 1-cycle internal event.
// - IDLE
//   - buttons_in[i] = 1 at edge t0: strobe at t0, cnt <= 0.
//   - Next state is DELAY, or REPEAT-free DELAY when REPEAT_DELAY_CYCLES = 0, meaning the FSM
//     stays in DELAY with no terminal count.
// - DELAY
//   - Button 0: go to IDLE, cnt <= 0.
//   - Otherwise, when cnt = REPEAT_DELAY_CYCLES-1: strobe, cnt <= 0, go to REPEAT.
//   - Otherwise cnt++.
// - REPEAT
//   - Button 0: go to IDLE.
//   - Otherwise, when cnt = REPEAT_PERIOD_CYCLES-1: strobe, cnt <= 0.
//   - Otherwise cnt++.
// - Strobe times are therefore t0, t0+D, t0+D+P, t0+D+2P, ... (D = delay, P = period).
// - Release on a terminal-count edge: release wins, no strobe is produced.
// - Latency: a strobe at edge t sets events_out[i], visible in the cycle after t (1-cycle latency).
// - Event register update at each edge, per bit:
//   - strobe: events <= 1. If events was already 1 and clear = 0, overrun <= 1.
//   - else if clear: events <= 0 and overrun <= 0.
//   - Strobe together with clear: set wins, events stays 1, overrun is not set (the old event
//     was acknowledged).
// - Clear on a bit that is already 0 has no effect; clear never affects the FSM.
// - held_out[i] is registered and equals (next state != IDLE). It rises with the press strobe
//   and falls the edge the release is sampled.
// - irq is combinational OR of the events_out flops, with no extra latency.
// - Reset asserted mid-operation (any state, any cnt) returns everything to reset values at once.
//   A button still held after reset deasserts produces a fresh press strobe on the first edge.
// - Channels are fully independent; simultaneous presses set several bits on the same edge.
// STRUCTURE
// - Package button_event_pkg:
//   - typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t.
//   - Default-timing localparams.
// - Sub-module button_repeat_fsm:
//   - One channel: state, cnt, strobe and held outputs.
//   - Instantiated N_BUTTONS times in a generate loop.
// - The top level holds the events/overrun registers and the irq OR.
// TESTING (bench params: D = 8, P = 3, N_BUTTONS = 4)
// - Reset: pulse reset -> all outputs 0.
//   Hold btn1 into REPEAT, assert reset -> events, held and irq are 0 in the same cycle.
//   Release reset with btn1 still held -> new strobe on the first edge.
// - Short press: btn0 = 1 for 5 cycles -> events_out = 4'b0001 one cycle later, irq = 1,
//   held_out[0] high for 5 cycles, no repeat. Clear 4'b0001 -> events 0, irq 0.
// - Repeat: hold btn2 for 20 cycles, clear after each event -> strobes at t0, +8, +11, +14, +17
//   (5 events). Same hold with no clears -> events[2] = 1 and overrun[2] = 1 after the second strobe.
// - Race: event_clear[1] on the same edge as a btn1 repeat strobe -> events[1] stays 1,
//   overrun[1] stays 0.
// - Release on terminal count: drop btn3 exactly at cnt = D-1 -> no strobe; FSM goes to IDLE
//   and held_out[3] = 0 next cycle.
// - Multi: btn0 and btn3 pressed on the same edge -> events 4'b1001.
//   Clear 4'b0001 -> events 4'b1000, irq still 1.
//   D = 0 build: 30-cycle hold -> exactly one event.

Source files
------------

// File: rtl/button_event_capture_pkg.sv
// Shared types and default timing for the debounced-button event path.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } btn_state_t;

  localparam int unsigned DEF_N_BUTTONS            = 4;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25_000_000;  // 0.5 s at 50 MHz
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5_000_000;   // 0.1 s at 50 MHz

  // The counter must be able to hold the larger of the two terminal counts.
  // The result is never allowed to drop below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned delay_cycles,
                                            input int unsigned period_cycles);
    int unsigned max_cycles;
    max_cycles = (delay_cycles > period_cycles) ? delay_cycles : period_cycles;
    return (max_cycles < 2) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_event_capture_if.sv
// Button levels and CPU-facing event/acknowledge signals of the capture block.
interface button_event_capture_if #(
  parameter int unsigned N_BUTTONS = 4
);
  logic [N_BUTTONS-1:0] buttons_in;   // debounced levels, 1 = pressed
  logic [N_BUTTONS-1:0] event_clear;  // write-1-to-clear pulse from the CPU
  logic [N_BUTTONS-1:0] events_out;   // sticky event flags
  logic [N_BUTTONS-1:0] overrun_out;  // sticky: event arrived while still pending
  logic [N_BUTTONS-1:0] held_out;     // channel FSM not IDLE
  logic                 irq;          // any event pending

  // Driver side: buttons and CPU.
  modport master (
    output buttons_in, event_clear,
    input  events_out, overrun_out, held_out, irq
  );

  // The capture block itself.
  modport slave (
    input  buttons_in, event_clear,
    output events_out, overrun_out, held_out, irq
  );
endinterface

// File: rtl/button_event_capture_repeat_fsm.sv
// One button channel: press detection plus auto-repeat timing.
// Emits a one-cycle strobe at press and at each repeat instant, and a
// registered "held" flag that is high while the channel is not IDLE.
module button_repeat_fsm
  import button_event_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic strobe_o,
  output logic held_o
);

  localparam int unsigned CNT_W          = cnt_width(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam bit          REPEAT_ENABLED = (REPEAT_DELAY_CYCLES != 0);
  localparam int unsigned DELAY_LAST_I   = REPEAT_ENABLED ? REPEAT_DELAY_CYCLES - 1 : 0;
  localparam int unsigned PERIOD_LAST_I  = (REPEAT_PERIOD_CYCLES != 0) ? REPEAT_PERIOD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_LAST_I);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_LAST_I);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;

  // Next-state, counter and strobe decode; a release always wins over a terminal count.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_i) begin
          strobe_o = 1'b1;
          cnt_d    = '0;
          state_d  = DELAY;
        end
      end
      DELAY: begin
        if (!btn_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REPEAT_ENABLED) begin
          if (cnt_q == DELAY_LAST) begin
            strobe_o = 1'b1;
            cnt_d    = '0;
            state_d  = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // With auto-repeat disabled the channel parks here with cnt frozen at 0.
      end
      REPEAT: begin
        if (!btn_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          strobe_o = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  // State, counter and held flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  assign held_o = held_q;

endmodule

// File: rtl/button_event_capture.sv
// Converts debounced button levels into sticky, CPU-acknowledged press
// events with auto-repeat. One repeat FSM per channel; this level holds the
// event/overrun flags and the interrupt OR.
module button_event_capture
  import button_event_pkg::*;
#(
  parameter int unsigned N_BUTTONS            = DEF_N_BUTTONS,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  button_event_capture_if.slave bus
);

  logic [N_BUTTONS-1:0] strobe;
  logic [N_BUTTONS-1:0] held;
  logic [N_BUTTONS-1:0] events_q, events_d;
  logic [N_BUTTONS-1:0] overrun_q, overrun_d;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_repeat_fsm #(
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (bus.buttons_in[g]),
      .strobe_o (strobe[g]),
      .held_o   (held[g])
    );
  end

  // Per-bit event update: a strobe sets the flag and wins over a same-edge clear;
  // overrun only flags an event that lands on one still unacknowledged.
  always_comb begin
    events_d  = events_q;
    overrun_d = overrun_q;
    for (int i = 0; i < int'(N_BUTTONS); i++) begin
      if (strobe[i]) begin
        events_d[i] = 1'b1;
        if (events_q[i] && !bus.event_clear[i]) begin
          overrun_d[i] = 1'b1;
        end
      end else if (bus.event_clear[i]) begin
        events_d[i]  = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  // Event and overrun flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      events_q  <= '0;
      overrun_q <= '0;
    end else begin
      events_q  <= events_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.events_out  = events_q;
  assign bus.overrun_out = overrun_q;
  assign bus.held_out    = held;
  assign bus.irq         = |events_q;

endmodule
